sram_ctrl: RTL and testbench

Bus-side initiator for the single-port SRAM block. It accepts one read or write burst request per transaction through a valid/ready handshake and drives the SRAM chip-select, write-enable, address and write-data pins. Write data is taken from a handshaked input stream. Read data is returned on a handshaked output stream, and the SRAM's one-cycle registered read latency is absorbed internally. The block sits between the CPU load/store path and the SRAM.

---
 rtl/sram_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - burst initiator for the single-port SRAM with handshaked write and read streams
module sram_ctrl #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             busy,
    output logic             sram_cs,
    output logic             sram_we,
    output logic [ADDR-1:0]  sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD} state_t;

    localparam logic [ADDR-1:0]  ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [ADDR-1:0]  addr_q, addr_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             done_n;

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        cnt_n      = cnt;
        done_n     = 1'b0;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = wr_data;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_n  = req_addr;
                    cnt_n   = req_len;
                    state_n = req_we ? WR : RD_ISSUE;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                // WE follows CS so a stalled beat never presents a bare write strobe
                sram_cs  = wr_valid;
                sram_we  = wr_valid;
                if (wr_valid) begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        addr_n = addr_q + ADDR_ONE;
                        cnt_n  = cnt - CNT_ONE;
                    end
                end
            end
            RD_ISSUE: begin
                sram_cs = 1'b1;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                state_n = RD_HOLD;
            end
            RD_HOLD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        addr_n  = addr_q + ADDR_ONE;
                        cnt_n   = cnt - CNT_ONE;
                        state_n = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            cnt     <= '0;
            rd_data <= '0;
            done    <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            done   <= done_n;
            // SRAM output is valid the cycle after the strobe, which is exactly RD_WAIT
            if (state == RD_WAIT) begin
                rd_data <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with SRAM model and scoreboard queues
module tb_sram_ctrl;
    localparam int ADDR  = 8;
    localparam int WIDTH = 32;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid, req_ready, req_we;
    logic [ADDR-1:0]  req_addr;
    logic [LEN_W-1:0] req_len;
    logic             wr_valid, wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid, rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             done, busy, sram_cs, sram_we;
    logic [ADDR-1:0]  sram_addr;
    logic [WIDTH-1:0] sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR(ADDR), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .busy(busy),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM with one-cycle registered read
    logic [WIDTH-1:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct packed {
        logic [ADDR-1:0]  a;
        logic [WIDTH-1:0] d;
    } wr_t;

    typedef struct {
        logic             we;
        logic [ADDR-1:0]  addr;
        logic [LEN_W-1:0] len;
        logic [WIDTH-1:0] base;
        int               stall_at;
        int               stall_n;
        logic [ADDR-1:0]  exp_last;
        int               exp_acc;
    } vec_t;

    int               n_vec = 0;
    int               n_bad = 0;
    int               acc = 0;
    int               done_cnt = 0;
    logic [ADDR-1:0]  last_addr = '0;
    logic [WIDTH-1:0] model [0:255];
    wr_t              exp_wr [$];
    logic [WIDTH-1:0] exp_rd [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [ADDR-1:0] a,
                            input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] base);
        for (int i = 0; i <= int'(len); i++) begin
            logic [ADDR-1:0] ai;
            ai = a + ADDR'(i);
            if (we) begin
                model[ai] = base + WIDTH'(i);
                exp_wr.push_back(wr_t'{a: ai, d: base + WIDTH'(i)});
            end else begin
                exp_rd.push_back(model[ai]);
            end
        end
    endtask

    task automatic issue(input logic we, input logic [ADDR-1:0] a, input logic [LEN_W-1:0] len);
        int t = 0;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_len   = len;
        tick();
        req_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic write_beats(input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] base,
                               input int stall_at, input int stall_n);
        int i = 0;
        int t = 0;
        int s = stall_n;
        while (i <= int'(len) && t < 200) begin
            if (i == stall_at && s > 0) begin
                wr_valid = 1'b0;
                s--;
            end else begin
                wr_valid = 1'b1;
                wr_data  = base + WIDTH'(i);
                if (wr_ready) i++;
            end
            tick();
            t++;
        end
        wr_valid = 1'b0;
        check("write_burst_in_time", t < 200, 1);
        check("write_done_pulse", done, 1);
        check("write_idle_after", busy, 0);
    endtask

    task automatic read_beats(input logic [LEN_W-1:0] len, input int stall_at, input int stall_n);
        int i = 0;
        int t = 0;
        int s = stall_n;
        int gap = 0;
        bit fresh = 1'b1;
        rd_ready = 1'b0;
        while (i <= int'(len) && t < 300) begin
            if (rd_valid) begin
                if (fresh) begin
                    check("read_beat_latency", gap, 2);
                    fresh = 1'b0;
                end
                if (i == stall_at && s > 0) begin
                    rd_ready = 1'b0;
                    s--;
                    if (exp_rd.size() > 0) check("rd_data_held", rd_data, exp_rd[0]);
                end else begin
                    rd_ready = 1'b1;
                    i++;
                    fresh = 1'b1;
                    gap = -1;
                end
            end else begin
                rd_ready = 1'b0;
            end
            tick();
            t++;
            gap++;
        end
        rd_ready = 1'b0;
        check("read_burst_in_time", t < 300, 1);
        check("read_done_pulse", done, 1);
        check("read_idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [8];
        wr_t  w;
        int   acc0, done0, t;

        vt[0] = '{1'b1, 8'h10, 4'd0,  32'hDEADBEEF, -1, 0, 8'h10, 1};
        vt[1] = '{1'b0, 8'h10, 4'd0,  32'h0,        -1, 0, 8'h10, 1};
        vt[2] = '{1'b1, 8'h20, 4'd3,  32'h1,         2, 2, 8'h23, 4};
        vt[3] = '{1'b0, 8'h20, 4'd3,  32'h0,         1, 5, 8'h23, 4};
        vt[4] = '{1'b1, 8'hFE, 4'd3,  32'hA0,       -1, 0, 8'h01, 4};
        vt[5] = '{1'b0, 8'hFE, 4'd3,  32'h0,        -1, 0, 8'h01, 4};
        vt[6] = '{1'b1, 8'h80, 4'd15, 32'h1000,     -1, 0, 8'h8F, 16};
        vt[7] = '{1'b0, 8'h80, 4'd15, 32'h0,        -1, 0, 8'h8F, 16};

        for (int i = 0; i < 256; i++) model[i] = '0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (sram_we) check("we_implies_cs", sram_cs, 1);
                if (sram_cs) begin
                    acc++;
                    last_addr = sram_addr;
                end
                if (sram_cs && sram_we) begin
                    if (exp_wr.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_sram_write: addr %0h data %0h, none expected", sram_addr, sram_wdata);
                    end else begin
                        w = exp_wr.pop_front();
                        check("sram_write_addr", sram_addr, w.a);
                        check("sram_write_data", sram_wdata, w.d);
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_read_beat: data %0h, none expected", rd_data);
                    end else begin
                        check("read_beat_data", rd_data, exp_rd.pop_front());
                    end
                end
                if (done) done_cnt++;
            end
        join_none

        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_req_ready", req_ready, 1);
        tick();
        rst = 1'b0;
        check("idle1_cs", sram_cs, 0);
        check("idle1_we", sram_we, 0);
        check("idle1_rd_valid", rd_valid, 0);
        check("idle1_wr_ready", wr_ready, 0);
        tick();

        for (int v = 0; v < 8; v++) begin
            acc0 = acc;
            push_exp(vt[v].we, vt[v].addr, vt[v].len, vt[v].base);
            issue(vt[v].we, vt[v].addr, vt[v].len);
            if (vt[v].we) write_beats(vt[v].len, vt[v].base, vt[v].stall_at, vt[v].stall_n);
            else          read_beats(vt[v].len, vt[v].stall_at, vt[v].stall_n);
            check("burst_last_addr", last_addr, vt[v].exp_last);
            check("burst_access_count", acc - acc0, vt[v].exp_acc);
            check("burst_queues_drained", exp_wr.size() + exp_rd.size(), 0);
            tick();
        end

        // reset while beat 2 of a 4-beat read is held
        exp_rd.push_back(model[8'h20]);
        issue(1'b0, 8'h20, 4'd3);
        t = 0;
        while (!rd_valid && t < 20) begin tick(); t++; end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        t = 0;
        while (!rd_valid && t < 20) begin tick(); t++; end
        check("rst_mid_reached_hold", rd_valid, 1);
        acc0  = acc;
        done0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_cs", sram_cs, 0);
        check("rst_mid_rd_valid", rd_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_no_access", acc - acc0, 0);
        check("rst_mid_no_done", done_cnt - done0, 0);
        check("rst_mid_queue", exp_rd.size(), 0);

        push_exp(1'b0, 8'h21, 4'd0, '0);
        issue(1'b0, 8'h21, 4'd0);
        read_beats(4'd0, -1, 0);
        check("post_rst_read_addr", last_addr, 8'h21);
        tick();

        // second request held valid across the first burst
        push_exp(1'b1, 8'h40, 4'd1, 32'h50);
        push_exp(1'b0, 8'h40, 4'd1, '0);
        issue(1'b1, 8'h40, 4'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_len = 4'd1;
        check("b2b_ready_low_busy", req_ready, 0);
        acc0 = acc;
        write_beats(4'd1, 32'h50, -1, 0);
        check("b2b_ready_in_done_cycle", req_ready, 1);
        check("b2b_not_accepted_early", acc - acc0, 2);
        tick();
        req_valid = 1'b0;
        check("b2b_accepted_busy", busy, 1);
        check("b2b_done_single", done, 0);
        read_beats(4'd1, -1, 0);
        tick();

        check("total_done_pulses", done_cnt, 11);
        check("final_queues_drained", exp_wr.size() + exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
